count_display: RTL

COUNT_DISPLAY -- requirements
Module: count_display

---
 rtl/display_pkg.sv | 25 ++
 rtl/seg7_decode.sv | 27 ++
 rtl/count_display.sv | 124 ++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared constants, FSM encoding and the double-dabble adjust step for the
// count display path.
package display_pkg;

  localparam int         BCD_DIGITS  = 4;
  localparam int         MAX_DISPLAY = 9999;
  localparam logic [6:0] SEG_BLANK   = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift.
  function automatic logic [4*BCD_DIGITS-1:0] dabble_adjust(input logic [4*BCD_DIGITS-1:0] acc);
    logic [4*BCD_DIGITS-1:0] r;
    r = acc;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) r[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment pattern (bit0 = a .. bit6 = g);
// codes 10-15 light nothing.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/count_display.sv
// Binary count to 4-digit BCD via serial double-dabble, plus a multiplexed
// seven-segment scan. Define COUNT_DISPLAY_BLANK_EN to blank leading zeros.
module count_display
  import display_pkg::*;
#(
  parameter int CNT_W       = 14,
  parameter int REFRESH_DIV = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] countIn,
  input  logic             countValid,
  output logic             busy,
  output logic [15:0]      bcd,
  output logic             bcdValid,
  output logic [6:0]       seg,
  output logic [3:0]       an,
  output logic             dp
);

  localparam int ITER_W = $clog2(CNT_W + 1);
  localparam int PRE_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  state_t            state;
  logic [CNT_W-1:0]  bin_q;
  logic [15:0]       acc_q;
  logic [ITER_W-1:0] iter_q;
  logic [CNT_W-1:0]  sat_in;
  logic [15:0]       adj;
  logic [15:0]       acc_next;
  logic [CNT_W-1:0]  bin_next;

  always_comb begin
    sat_in = countIn;
    if (int'(countIn) > MAX_DISPLAY) sat_in = CNT_W'(MAX_DISPLAY);
  end

  always_comb begin
    adj      = dabble_adjust(acc_q);
    acc_next = {adj[14:0], bin_q[CNT_W-1]};
    bin_next = {bin_q[CNT_W-2:0], 1'b0};
  end

  // Strobes arriving outside IDLE fall through the case and are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      bcdValid <= 1'b0;
      bcd      <= '0;
      acc_q    <= '0;
      bin_q    <= '0;
      iter_q   <= '0;
    end else begin
      bcdValid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (countValid) begin
            bin_q  <= sat_in;
            acc_q  <= '0;
            iter_q <= '0;
            busy   <= 1'b1;
            state  <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          acc_q  <= acc_next;
          bin_q  <= bin_next;
          iter_q <= iter_q + 1'b1;
          if (iter_q == ITER_W'(CNT_W - 1)) state <= ST_DONE;
        end
        ST_DONE: begin
          bcd      <= acc_q;
          bcdValid <= 1'b1;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic [PRE_W-1:0] prescale;
  logic [1:0]       idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      prescale <= '0;
      idx      <= '0;
    end else if (prescale == PRE_W'(REFRESH_DIV - 1)) begin
      prescale <= '0;
      idx      <= idx + 2'd1;
    end else begin
      prescale <= prescale + 1'b1;
    end
  end

  // bcd doubles as the digit register bank: it is written only in DONE.
  logic [3:0] digit;
  logic [3:0] dec_in;

  always_comb begin
    digit = bcd[{idx, 2'b00} +: 4];
    an    = ~(4'b0001 << idx);
`ifdef COUNT_DISPLAY_BLANK_EN
    case (idx)
      2'd1:    dec_in = (bcd[15:4]  == '0) ? 4'hF : digit;
      2'd2:    dec_in = (bcd[15:8]  == '0) ? 4'hF : digit;
      2'd3:    dec_in = (bcd[15:12] == '0) ? 4'hF : digit;
      default: dec_in = digit;
    endcase
`else
    dec_in = digit;
`endif
  end

  seg7_decode u_dec (
    .digit (dec_in),
    .seg   (seg)
  );

  assign dp = 1'b1;

endmodule
